// File: rtl/ysyx_22050133_icache.sv
// Set-associative, read-only instruction cache. Misses refill a whole line
// from memory in ascending word order; flush invalidates every line.
module ysyx_22050133_icache #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 4,
    parameter int WAYS         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    input  logic                  flush,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);
    localparam int SETS     = 1 << INDEX_WIDTH;
    localparam int BEATS    = (1 << OFFSET_WIDTH) * 8 / DATA_WIDTH;
    localparam int WORD_LSB = $clog2(DATA_WIDTH / 8);
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP, FLUSH} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [BEAT_W-1:0]            beat_q, beat_d;
    logic [WAY_W-1:0]             victim_q, victim_d;
    logic                         flush_pend_q, flush_pend_d;
    logic [31:0]                  hit_cnt_q, hit_cnt_d;
    logic [31:0]                  miss_cnt_q, miss_cnt_d;
    logic [DATA_WIDTH-1:0]        resp_data_q, resp_data_d;
    logic [WAYS-1:0][SETS-1:0]    valid_q, valid_d;

    logic [TAG_W-1:0]             tag_mem  [WAYS][SETS];
    logic [DATA_WIDTH-1:0]        data_mem [WAYS][SETS][BEATS];

    logic [INDEX_WIDTH-1:0]       idx;
    logic [TAG_W-1:0]             tag;
    logic [BEAT_W-1:0]            word_idx;
    logic [WAYS-1:0]              hit_way;
    logic [DATA_WIDTH-1:0]        hit_data;
    logic                         free_found;
    logic [WAY_W-1:0]             free_way;
    logic [WAY_W-1:0]             rr_way;
    logic [WAY_W-1:0]             victim;
    logic                         refill_done;

    assign idx         = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
    assign tag         = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign word_idx    = BEAT_W'((addr_q >> WORD_LSB) & (BEATS - 1));
    assign refill_done = (state_q == REFILL) && mem_resp_valid && (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        hit_way  = '0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_way[w] = valid_q[w][idx] && (tag_mem[w][idx] == tag);
            if (hit_way[w]) hit_data = hit_data | data_mem[w][idx][word_idx];
        end
    end

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][idx]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
    end

    assign victim = free_found ? free_way : rr_way;

    if (WAYS > 1) begin : g_rr
        logic [SETS-1:0][WAY_W-1:0] rr_q, rr_d;

        always_comb begin
            rr_d = rr_q;
            if (state_q == FLUSH) rr_d = '0;
            else if (refill_done) rr_d[idx] = rr_q[idx] + 1'b1;
        end

        always_ff @(posedge clk) begin
            if (rst) rr_q <= '0;
            else     rr_q <= rr_d;
        end

        assign rr_way = rr_q[idx];
    end else begin : g_no_rr
        assign rr_way = '0;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        victim_d     = victim_q;
        valid_d      = valid_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        resp_data_d  = resp_data_q;
        flush_pend_d = flush_pend_q | flush;
        case (state_q)
            IDLE: begin
                if (flush_pend_q || flush) begin
                    state_d = FLUSH;
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (|hit_way) begin
                    resp_data_d = hit_data;
                    hit_cnt_d   = hit_cnt_q + 32'd1;
                    state_d     = RESP;
                end else begin
                    victim_d   = victim;
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d    = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_resp_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == word_idx) resp_data_d = mem_resp_data;
                    // The line only becomes visible once every beat has landed.
                    if (refill_done) begin
                        valid_d[victim_q][idx] = 1'b1;
                        beat_d                 = '0;
                        state_d                = RESP;
                    end
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            FLUSH: begin
                valid_d      = '0;
                flush_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            victim_q     <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            victim_q     <= victim_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            resp_data_q  <= resp_data_d;
        end
        addr_q <= addr_d;
    end

    always_ff @(posedge clk) begin
        if (state_q == REFILL && mem_resp_valid) begin
            data_mem[victim_q][idx][beat_q] <= mem_resp_data;
            if (refill_done) tag_mem[victim_q][idx] <= tag;
        end
    end

    assign req_ready     = (state_q == IDLE) && !flush_pend_q && !flush && !rst;
    assign resp_valid    = (state_q == RESP);
    assign resp_data     = resp_data_q;
    assign mem_req_valid = (state_q == MISS_REQ);
    assign mem_req_addr  = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_ysyx_22050133_icache.sv
// Directed bench for the instruction cache: a table of reads with expected
// hit/miss, data and counters, plus flush-during-refill and reset-during-refill.
module tb_ysyx_22050133_icache;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_data;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        flush;
    logic [31:0] hit_cnt, miss_cnt;

    int total  = 0;
    int passed = 0;

    ysyx_22050133_icache dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .flush(flush), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // More than one matching way must never happen.
    always @(negedge clk) begin
        if (!rst && !$onehot0(dut.hit_way)) begin
            total++;
            $display("FAIL multi_hit: hit_way=%b expected at most one bit", dut.hit_way);
        end
    end

    // Memory contents: line 0x8000_0000 holds 0x11,0x22; others {C0DE000k, line}.
    function automatic logic [63:0] beat_val(input logic [31:0] line, input int k);
        if (line == 32'h8000_0000) return (k == 0) ? 64'h11 : 64'h22;
        return {32'hC0DE_0000 | 32'(k), line};
    endfunction

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        logic [63:0] data;
        int          hold;
        int          hits;
        int          misses;
    } vec_t;

    // mode: 0 normal, 1 flush pulse on first refill beat, 2 reset after first beat
    task automatic do_read(input string nm, input logic [31:0] addr, input bit miss,
                           input logic [63:0] exp_data, input int hold, input int mode,
                           input int exp_hits, input int exp_misses);
        logic [31:0] line;
        int i;
        bit got;
        line = addr & ~32'hF;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        got = 1'b0;
        for (i = 0; i < 20; i++) begin
            if (req_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin chk({nm, "_req_timeout"}, 0, 1); req_valid = 1'b0; return; end
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_lookup_rv"}, 64'(resp_valid), 0);
        @(negedge clk);
        if (!miss) begin
            chk({nm, "_hit_rv"}, 64'(resp_valid), 1);
            chk({nm, "_hit_nomem"}, 64'(mem_req_valid), 0);
        end else begin
            chk({nm, "_mreq_v"}, 64'(mem_req_valid), 1);
            chk({nm, "_mreq_a"}, 64'(mem_req_addr), 64'(line));
            @(negedge clk);
            chk({nm, "_mreq_stable"}, {31'b0, mem_req_valid, mem_req_addr}, {31'b0, 1'b1, line});
            mem_req_ready = 1'b1;
            @(posedge clk); #1 mem_req_ready = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                mem_resp_valid = 1'b1;
                mem_resp_data  = beat_val(line, k);
                if (mode == 1 && k == 0) flush = 1'b1;
                @(posedge clk); #1 mem_resp_valid = 1'b0;
                flush = 1'b0;
                if (mode == 2) begin
                    rst = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    chk({nm, "_rst_outs"},
                        {req_ready, resp_valid, mem_req_valid, 61'b0},
                        64'b0);
                    chk({nm, "_rst_data"}, resp_data, 0);
                    chk({nm, "_rst_cnt"}, {hit_cnt, miss_cnt}, 0);
                    rst = 1'b0;
                    return;
                end
            end
            @(negedge clk);
            chk({nm, "_miss_rv"}, 64'(resp_valid), 1);
        end
        chk({nm, "_data"}, resp_data, exp_data);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_hold"}, {resp_valid, req_ready, resp_data[61:0]}, {1'b1, 1'b0, exp_data[61:0]});
        end
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
        chk({nm, "_cnt"}, {hit_cnt, miss_cnt}, {32'(exp_hits), 32'(exp_misses)});
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h8000_0008, 1, 64'h22,                  0, 0, 1};
        vecs[1] = '{32'h8000_0000, 0, 64'h11,                  5, 1, 1};
        vecs[2] = '{32'h8000_0400, 1, 64'hC0DE0000_80000400,   0, 1, 2};
        vecs[3] = '{32'h8000_0808, 1, 64'hC0DE0001_80000800,   0, 1, 3};
        vecs[4] = '{32'h8000_0408, 0, 64'hC0DE0001_80000400,   0, 2, 3};
        vecs[5] = '{32'h8000_0000, 1, 64'h11,                  2, 2, 4};
        vecs[6] = '{32'h8000_0800, 0, 64'hC0DE0000_80000800,   0, 3, 4};
        vecs[7] = '{32'h8000_0400, 1, 64'hC0DE0000_80000400,   0, 3, 5};
        vecs[8] = '{32'h8000_0010, 1, 64'hC0DE0000_80000010,   0, 3, 6};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {req_ready, resp_valid, mem_req_valid, 61'b0}, 64'b0);
        chk("reset_data", resp_data, 0);
        chk("reset_cnt", {hit_cnt, miss_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(req_ready), 1);

        for (int v = 0; v < 9; v++)
            do_read($sformatf("vec%0d", v), vecs[v].addr, vecs[v].miss, vecs[v].data,
                    vecs[v].hold, 0, vecs[v].hits, vecs[v].misses);

        // Flush during refill: transaction completes, then FLUSH drops the line.
        do_read("flush_refill", 32'h8000_1000, 1, 64'hC0DE0000_80001000, 0, 1, 3, 7);
        @(negedge clk); chk("flush_pend_ready", 64'(req_ready), 0);
        @(negedge clk); chk("flush_cyc_ready", 64'(req_ready), 0);
        @(negedge clk); chk("post_flush_ready", 64'(req_ready), 1);
        do_read("after_flush", 32'h8000_1000, 1, 64'hC0DE0000_80001000, 0, 0, 3, 8);
        do_read("after_flush_b", 32'h8000_0010, 1, 64'hC0DE0000_80000010, 0, 0, 3, 9);

        // Reset after the first refill beat abandons the line.
        do_read("rst_refill", 32'h8000_2000, 1, 64'h0, 0, 2, 0, 0);
        do_read("rst_reread", 32'h8000_2000, 1, 64'hC0DE0000_80002000, 0, 0, 0, 1);
        do_read("rst_reread_hit", 32'h8000_2008, 0, 64'hC0DE0001_80002000, 0, 0, 1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
